// File: rtl/flow_qtable.sv
// flow_qtable: tracks coefficient position per beat and attaches per-position multipliers.
// Define FLOW_QTABLE_ZIGZAG_EN when the stream is zigzag ordered and the tables are raster ordered.
module flow_qtable #(
    parameter  int N      = 2,
    parameter  int TABLES = 2,
    localparam int TW     = (TABLES > 1) ? $clog2(TABLES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic signed [N-1:0][15:0] in_data,
    input  logic                     in_eob,
    input  logic                     in_sob,
    input  logic                     in_sof,
    input  logic [TW-1:0]            in_table,
    input  logic                     cfg_we,
    input  logic [TW-1:0]            cfg_table,
    input  logic [5:0]               cfg_addr,
    input  logic [9:0]               cfg_data,
    output logic                     out_valid,
    output logic signed [N-1:0][15:0] out_data,
    output logic [N-1:0][9:0]        out_mult,
    output logic                     out_eob,
    output logic                     out_sob,
    output logic                     out_sof,
    output logic                     out_err
);

    localparam int BPB = 64 / N;
    localparam int BW  = (BPB > 1) ? $clog2(BPB) : 1;
    localparam logic [BW-1:0] LAST = BW'(BPB - 1);

`ifdef FLOW_QTABLE_ZIGZAG_EN
    localparam logic [0:63][5:0] ZZ2R = {
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
`endif

    logic                 acc;
    logic [BW-1:0]        bcnt_q, bcnt_d, eb;
    logic [TW-1:0]        tsel_q, tsel_d, tin, sel;
    logic [9:0]           tbl_q [TABLES][64];
    logic [N-1:0][5:0]    pos, addr;
    logic [N-1:0][9:0]    mult_d;
    logic                 err_d;

    always_comb begin
        acc    = in_valid & en;
        eb     = in_sob ? '0 : bcnt_q;
        tin    = (int'(in_table) < TABLES) ? in_table : '0;
        sel    = in_sob ? tin : tsel_q;
        bcnt_d = bcnt_q;
        tsel_d = tsel_q;
        if (acc) begin
            bcnt_d = (in_eob || eb == LAST) ? '0 : eb + 1'b1;
            if (in_sob) tsel_d = tin;
        end
        err_d = in_eob != (eb == LAST);
        for (int i = 0; i < N; i++) begin
            pos[i] = 6'(int'(eb) * N + i);
`ifdef FLOW_QTABLE_ZIGZAG_EN
            addr[i] = ZZ2R[pos[i]];
`else
            addr[i] = pos[i];
`endif
            mult_d[i] = tbl_q[sel][addr[i]];
        end
    end

    // Table reads above see the pre-write value; writes land at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TABLES; t++)
                for (int a = 0; a < 64; a++)
                    tbl_q[t][a] <= 10'd1;
        end else if (cfg_we && int'(cfg_table) < TABLES) begin
            tbl_q[cfg_table][cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q    <= '0;
            tsel_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mult  <= '0;
            out_eob   <= 1'b0;
            out_sob   <= 1'b0;
            out_sof   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            bcnt_q    <= bcnt_d;
            tsel_q    <= tsel_d;
            out_valid <= acc;
            out_eob   <= acc & in_eob;
            out_sob   <= acc & in_sob;
            out_sof   <= acc & in_sof;
            out_err   <= acc & err_d;
            if (acc) begin
                out_data <= in_data;
                out_mult <= mult_d;
            end
        end
    end

endmodule

// File: tb/tb_flow_qtable.sv
// tb_flow_qtable: directed bench for flow_qtable with N=2, TABLES=2.
module tb_flow_qtable;

    localparam int N = 2;
    localparam int TABLES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic in_valid = 1'b0;
    logic signed [N-1:0][15:0] in_data = '0;
    logic in_eob = 1'b0;
    logic in_sob = 1'b0;
    logic in_sof = 1'b0;
    logic [0:0] in_table = '0;
    logic cfg_we = 1'b0;
    logic [0:0] cfg_table = '0;
    logic [5:0] cfg_addr = '0;
    logic [9:0] cfg_data = '0;
    logic out_valid;
    logic signed [N-1:0][15:0] out_data;
    logic [N-1:0][9:0] out_mult;
    logic out_eob, out_sob, out_sof, out_err;

    int total = 0;
    int bad = 0;

    flow_qtable #(.N(N), .TABLES(TABLES)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_data(in_data),
        .in_eob(in_eob), .in_sob(in_sob), .in_sof(in_sof),
        .in_table(in_table),
        .cfg_we(cfg_we), .cfg_table(cfg_table),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_data(out_data),
        .out_mult(out_mult), .out_eob(out_eob),
        .out_sob(out_sob), .out_sof(out_sof), .out_err(out_err)
    );

    always #5 clk = ~clk;

`ifdef FLOW_QTABLE_ZIGZAG_EN
    localparam int ZZ [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
    function automatic int raddr(input int p);
        return ZZ[p];
    endfunction
`else
    function automatic int raddr(input int p);
        return p;
    endfunction
`endif

    task automatic drive(input logic v, input logic e, input int b,
                         input logic sob, input logic eob,
                         input logic sof, input logic [0:0] tbl);
        in_valid = v;
        en = e;
        in_sob = sob;
        in_eob = eob;
        in_sof = sof;
        in_table = tbl;
        for (int i = 0; i < N; i++) in_data[i] = 16'(b * N + i);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_mult !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL rst_data got=%h/%h want=0", out_mult, out_data);
        end
        total++;
        if ({out_sob, out_eob, out_sof, out_err} !== 4'b0) begin
            bad++;
            $display("FAIL rst_ctl got=%b want=0000",
                     {out_sob, out_eob, out_sof, out_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_default_table;
        for (int b = 0; b < 32; b++) begin
            drive(1, 1, b, b == 0, b == 31, b == 0, 0);
            total++;
            if (out_mult[0] !== 10'd1 || out_mult[1] !== 10'd1) begin
                bad++;
                $display("FAIL def_mult b=%0d got=%h want=1,1", b, out_mult);
            end
            total++;
            if (out_data[0] !== 16'(2 * b) || out_data[1] !== 16'(2 * b + 1)) begin
                bad++;
                $display("FAIL def_data b=%0d got=%h want=%0d,%0d",
                         b, out_data, 2 * b + 1, 2 * b);
            end
            total++;
            if ({out_valid, out_err, out_sob, out_eob, out_sof} !==
                {1'b1, 1'b0, b == 0, b == 31, b == 0}) begin
                bad++;
                $display("FAIL def_ctl b=%0d got=%b", b,
                         {out_valid, out_err, out_sob, out_eob, out_sof});
            end
        end
        drive(0, 1, 50, 0, 0, 0, 0);
        total++;
        if (out_valid !== 1'b0 || out_data[0] !== 16'd62) begin
            bad++;
            $display("FAIL idle_hold got=%b/%0d want=0/62", out_valid, out_data[0]);
        end
    endtask

    task automatic test_program_table;
        in_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            cfg_we = 1'b1;
            cfg_table = 1'b1;
            cfg_addr = 6'(k);
            cfg_data = 10'(k + 10);
            @(posedge clk);
            #1;
        end
        cfg_we = 1'b0;
        for (int b = 0; b < 32; b++) begin
            drive(1, 1, b, b == 0, b == 31, 0, b == 0 ? 1'b1 : 1'b0);
            for (int i = 0; i < N; i++) begin
                total++;
                if (out_mult[i] !== 10'(raddr(2 * b + i) + 10)) begin
                    bad++;
                    $display("FAIL prog_mult b=%0d i=%0d got=%0d want=%0d",
                             b, i, out_mult[i], raddr(2 * b + i) + 10);
                end
            end
            total++;
            if ({out_sob, out_eob, out_err} !== {b == 0, b == 31, 1'b0}) begin
                bad++;
                $display("FAIL prog_ctl b=%0d got=%b", b, {out_sob, out_eob, out_err});
            end
        end
    endtask

    task automatic test_enable_stall;
        for (int b = 0; b < 10; b++) drive(1, 1, b, b == 0, 0, 0, b == 0 ? 1'b1 : 1'b0);
        for (int s = 0; s < 3; s++) begin
            drive(1, 0, 40, 0, 0, 0, 0);
            total++;
            if (out_valid !== 1'b0 || out_data[0] !== 16'd18 ||
                out_mult[0] !== 10'(raddr(18) + 10)) begin
                bad++;
                $display("FAIL stall s=%0d got=%b/%0d/%0d want=0/18/%0d",
                         s, out_valid, out_data[0], out_mult[0], raddr(18) + 10);
            end
        end
        for (int b = 10; b < 32; b++) begin
            drive(1, 1, b, 0, b == 31, 0, 0);
            total++;
            if (out_mult[0] !== 10'(raddr(2 * b) + 10) || out_err !== 1'b0) begin
                bad++;
                $display("FAIL resume b=%0d got=%0d/%b want=%0d/0",
                         b, out_mult[0], out_err, raddr(2 * b) + 10);
            end
        end
    endtask

    task automatic test_short_block;
        for (int b = 0; b <= 20; b++) begin
            drive(1, 1, b, b == 0, b == 20, 0, b == 0 ? 1'b1 : 1'b0);
            total++;
            if (out_err !== (b == 20)) begin
                bad++;
                $display("FAIL short_err b=%0d got=%b want=%b", b, out_err, b == 20);
            end
        end
        for (int b = 0; b < 32; b++) begin
            drive(1, 1, b, b == 0, b == 31, 0, b == 0 ? 1'b1 : 1'b0);
            total++;
            if (out_mult[0] !== 10'(raddr(2 * b) + 10) ||
                out_mult[1] !== 10'(raddr(2 * b + 1) + 10) || out_err !== 1'b0) begin
                bad++;
                $display("FAIL after_short b=%0d got=%h/%b", b, out_mult, out_err);
            end
        end
    endtask

    task automatic test_long_block;
        for (int b = 0; b < 32; b++) begin
            drive(1, 1, b, b == 0, 0, 0, b == 0 ? 1'b1 : 1'b0);
            total++;
            if (out_err !== (b == 31)) begin
                bad++;
                $display("FAIL long_err b=%0d got=%b want=%b", b, out_err, b == 31);
            end
        end
        for (int b = 0; b < 5; b++) drive(1, 1, b, 0, 0, 0, 0);
        total++;
        if (out_mult[0] !== 10'(raddr(8) + 10) || out_err !== 1'b0) begin
            bad++;
            $display("FAIL wrap got=%0d/%b want=%0d/0", out_mult[0], out_err, raddr(8) + 10);
        end
        drive(1, 1, 0, 1, 0, 0, 1);
        total++;
        if (out_mult[0] !== 10'(raddr(0) + 10) || out_err !== 1'b0) begin
            bad++;
            $display("FAIL resync got=%0d/%b want=%0d/0", out_mult[0], out_err, raddr(0) + 10);
        end
        for (int b = 1; b < 32; b++) begin
            drive(1, 1, b, 0, b == 31, 0, 0);
            total++;
            if (out_err !== 1'b0 || out_mult[1] !== 10'(raddr(2 * b + 1) + 10)) begin
                bad++;
                $display("FAIL resync_blk b=%0d got=%0d/%b", b, out_mult[1], out_err);
            end
        end
    endtask

    task automatic test_cfg_collision;
        for (int b = 0; b < 32; b++) begin
            if (b == 2) begin
                cfg_we = 1'b1;
                cfg_table = 1'b0;
                cfg_addr = 6'(raddr(4));
                cfg_data = 10'd777;
            end
            drive(1, 1, b, b == 0, b == 31, 0, 0);
            cfg_we = 1'b0;
            if (b == 2) begin
                total++;
                if (out_mult[0] !== 10'd1) begin
                    bad++;
                    $display("FAIL coll_old got=%0d want=1", out_mult[0]);
                end
            end
        end
        for (int b = 0; b < 3; b++) drive(1, 1, b, b == 0, 0, 0, 0);
        total++;
        if (out_mult[0] !== 10'd777 || out_mult[1] !== 10'd1) begin
            bad++;
            $display("FAIL coll_new got=%0d,%0d want=777,1", out_mult[0], out_mult[1]);
        end
    endtask

`ifdef FLOW_QTABLE_ZIGZAG_EN
    task automatic test_zigzag;
        in_valid = 1'b0;
        cfg_we = 1'b1;
        cfg_table = 1'b0;
        cfg_addr = 6'd8;
        cfg_data = 10'd99;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        drive(1, 1, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0);
        total++;
        if (out_mult[0] !== 10'd99 || out_mult[1] !== 10'd1) begin
            bad++;
            $display("FAIL zigzag got=%0d,%0d want=99,1", out_mult[0], out_mult[1]);
        end
    endtask
`endif

    task automatic test_reset_mid;
        for (int b = 0; b < 4; b++) drive(1, 1, b, b == 0, 0, 0, b == 0 ? 1'b1 : 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_mult !== '0 || out_data !== '0) begin
            bad++;
            $display("FAIL async_rst got=%b/%h/%h want=0", out_valid, out_mult, out_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int b = 0; b < 32; b++) begin
            drive(1, 1, b, b == 0, b == 31, 0, b == 0 ? 1'b1 : 1'b0);
            total++;
            if (out_mult[0] !== 10'd1 || out_mult[1] !== 10'd1 || out_err !== 1'b0) begin
                bad++;
                $display("FAIL post_rst b=%0d got=%h/%b want=1,1/0", b, out_mult, out_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_table();
        test_program_table();
        test_enable_stall();
        test_short_block();
        test_long_block();
        test_cfg_collision();
`ifdef FLOW_QTABLE_ZIGZAG_EN
        test_zigzag();
`endif
        test_reset_mid();
        drive(0, 1, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
